// File: rtl/toggle_counter_param.sv
// toggle_counter_param: WIDTH-bit up/down counter with a masked-toggle mode,
// parallel load, optional saturation at the limits, a registered one-cycle
// wrap pulse and a combinational terminal-count flag.
module toggle_counter_param #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t_mask,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_inverse,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_TOGGLE = 2'b11;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_q;
  logic             wrap_d;

  // Next-state selection: load wins, then enabled mode action, else hold.
  // Plain case equality means X/Z on load, en or mode matches no item and
  // falls through to the hold default, keeping unknowns out of the state.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    case ({load, en})
      2'b10, 2'b11: begin
        cnt_d = d;
      end
      2'b01: begin
        case (mode)
          MODE_HOLD: begin
            cnt_d = cnt_q;
          end
          MODE_UP: begin
            if (cnt_q == ALL_ONES) begin
              if (SATURATE != 0) begin
                cnt_d = cnt_q;
              end else begin
                cnt_d  = ALL_ZERO;
                wrap_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
          MODE_DOWN: begin
            if (cnt_q == ALL_ZERO) begin
              if (SATURATE != 0) begin
                cnt_d = cnt_q;
              end else begin
                cnt_d  = ALL_ONES;
                wrap_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
          MODE_TOGGLE: begin
            cnt_d = cnt_q ^ t_mask;
          end
          default: begin
            cnt_d = cnt_q;
          end
        endcase
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // State and wrap-pulse registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= ALL_ZERO;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  // Terminal count looks only at mode and the current state, never en/load.
  always_comb begin
    tc = 1'b0;
    if ((mode == MODE_UP) && (cnt_q == ALL_ONES)) begin
      tc = 1'b1;
    end else if ((mode == MODE_DOWN) && (cnt_q == ALL_ZERO)) begin
      tc = 1'b1;
    end else begin
      tc = 1'b0;
    end
  end

  // The complement is taken straight from the state register so it can
  // never disagree with q, including while reset is held.
  assign q         = cnt_q;
  assign q_inverse = ~cnt_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_toggle_counter_param.sv
// Bench for toggle_counter_param: three instances (4-bit wrap, 4-bit
// saturate, 8-bit wrap) share one stimulus stream and are compared against
// an arithmetic reference model after every edge.
module tb_toggle_counter_param;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [7:0] d8;
  logic [7:0] tm8;

  logic [3:0] qa, qia, qb, qib;
  logic [7:0] qc, qic;
  logic       tca, tcb, tcc, wa, wb, wc;

  int vectors;
  int miscompares;

  int model_q [3];
  bit model_w [3];
  int widths  [3] = '{4, 4, 8};
  bit sats    [3] = '{1'b0, 1'b1, 1'b0};

  toggle_counter_param #(.WIDTH(4), .SATURATE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t_mask(tm8[3:0]),
    .load(load), .d(d8[3:0]), .q(qa), .q_inverse(qia), .tc(tca), .wrap(wa));

  toggle_counter_param #(.WIDTH(4), .SATURATE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t_mask(tm8[3:0]),
    .load(load), .d(d8[3:0]), .q(qb), .q_inverse(qib), .tc(tcb), .wrap(wb));

  toggle_counter_param #(.WIDTH(8), .SATURATE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .t_mask(tm8),
    .load(load), .d(d8), .q(qc), .q_inverse(qic), .tc(tcc), .wrap(wc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] obs_q(input int i);
    if (i == 0) return {28'd0, qa};
    else if (i == 1) return {28'd0, qb};
    else return {24'd0, qc};
  endfunction

  function automatic logic [31:0] obs_qi(input int i);
    if (i == 0) return {28'd0, qia};
    else if (i == 1) return {28'd0, qib};
    else return {24'd0, qic};
  endfunction

  function automatic logic obs_w(input int i);
    if (i == 0) return wa;
    else if (i == 1) return wb;
    else return wc;
  endfunction

  function automatic logic obs_tc(input int i);
    if (i == 0) return tca;
    else if (i == 1) return tcb;
    else return tcc;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_all_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      int mx;
      mx = (1 << widths[i]) - 1;
      check($sformatf("%s_q%0d", tag, i), obs_q(i), model_q[i]);
      check($sformatf("%s_qinv%0d", tag, i), obs_qi(i), (~model_q[i]) & mx);
      check($sformatf("%s_wrap%0d", tag, i), {31'd0, obs_w(i)}, {31'd0, model_w[i]});
    end
  endtask

  // One clock step: drive after the falling edge, check tc before the
  // rising edge, advance the model, check state 1 time unit after it.
  task automatic apply(input string tag, input logic ld, input logic e,
                       input logic [1:0] md, input logic [7:0] dd, input logic [7:0] tm);
    @(negedge clk);
    load = ld; en = e; mode = md; d8 = dd; tm8 = tm;
    #1;
    if (!$isunknown(md)) begin
      for (int i = 0; i < 3; i++) begin
        int mx;
        bit exp_tc;
        mx = (1 << widths[i]) - 1;
        exp_tc = (md == 2'b01 && model_q[i] == mx) || (md == 2'b10 && model_q[i] == 0);
        check($sformatf("%s_tc%0d", tag, i), {31'd0, obs_tc(i)}, {31'd0, exp_tc});
      end
    end
    for (int i = 0; i < 3; i++) begin
      int mx;
      int q;
      mx = (1 << widths[i]) - 1;
      q = model_q[i];
      model_w[i] = 1'b0;
      if (ld === 1'b1) begin
        q = int'(dd) & mx;
      end else if (ld === 1'b0 && e === 1'b1 && !$isunknown(md)) begin
        if (md == 2'b01) begin
          if (q == mx) begin
            if (!sats[i]) begin q = 0; model_w[i] = 1'b1; end
          end else q = q + 1;
        end else if (md == 2'b10) begin
          if (q == 0) begin
            if (!sats[i]) begin q = mx; model_w[i] = 1'b1; end
          end else q = q - 1;
        end else if (md == 2'b11) begin
          q = q ^ (int'(tm) & mx);
        end
      end
      model_q[i] = q;
    end
    @(posedge clk);
    #1;
    check_all_state(tag);
  endtask

  // Assert reset between edges, verify immediate clear, let edges pass
  // with a load pending, then release on a falling edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      model_q[i] = 0;
      model_w[i] = 1'b0;
    end
    check_all_state({tag, "_imm"});
    load = 1'b1; en = 1'b1; mode = 2'b01; d8 = 8'h5A; tm8 = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check_all_state({tag, "_held"});
    @(negedge clk);
    rst_n = 1'b1;
    load = 1'b0; en = 1'b0; mode = 2'b00;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 3; i++) begin
      model_q[i] = 0;
      model_w[i] = 1'b0;
    end
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; load = 1'b0; d8 = 8'h00; tm8 = 8'h00;
    #12;
    check_all_state("por");
    rst_n = 1'b1;

    // Masked toggle of bit 0: 1,0,1,0 with complement E,F,E,F.
    for (int k = 0; k < 4; k++) begin
      apply("tog", 1'b0, 1'b1, 2'b11, 8'h00, 8'h01);
      check("tog_direct_q", {28'd0, qa}, (k % 2 == 0) ? 32'h1 : 32'h0);
      check("tog_direct_qi", {28'd0, qia}, (k % 2 == 0) ? 32'hE : 32'hF);
    end
    apply("tog_zero_mask", 1'b0, 1'b1, 2'b11, 8'h00, 8'h00);

    // Up through the wrap from E; saturating instance from 1 goes down.
    apply("ld_e", 1'b1, 1'b0, 2'b00, 8'h0E, 8'h00);
    apply("up1", 1'b0, 1'b1, 2'b01, 8'h00, 8'h00);
    check("up1_direct", {28'd0, qa}, 32'hF);
    apply("up2", 1'b0, 1'b1, 2'b01, 8'h00, 8'h00);
    check("up2_direct_q", {28'd0, qa}, 32'h0);
    check("up2_direct_wrap", {31'd0, wa}, 32'h1);
    check("up2_sat_hold", {28'd0, qb}, 32'hF);
    apply("up3", 1'b0, 1'b1, 2'b01, 8'h00, 8'h00);
    check("up3_direct_wrap", {31'd0, wa}, 32'h0);

    apply("ld_1", 1'b1, 1'b1, 2'b10, 8'h01, 8'h00);
    for (int k = 0; k < 3; k++) begin
      apply("down", 1'b0, 1'b1, 2'b10, 8'h00, 8'h00);
      check("down_sat_direct", {28'd0, qb}, 32'h0);
      check("down_sat_nowrap", {31'd0, wb}, 32'h0);
    end

    // Load beats count on the same edge, then en=0 holds.
    apply("ld_9", 1'b1, 1'b1, 2'b01, 8'h09, 8'h00);
    check("ld_9_direct", {28'd0, qa}, 32'h9);
    apply("en0a", 1'b0, 1'b0, 2'b01, 8'h00, 8'hFF);
    apply("en0b", 1'b0, 1'b0, 2'b11, 8'h00, 8'hFF);
    check("en0_direct", {28'd0, qa}, 32'h9);
    apply("hold00", 1'b0, 1'b1, 2'b00, 8'h33, 8'hFF);

    // Unknown mode or load with en=1 must hold.
    apply("xmode", 1'b0, 1'b1, 2'bxx, 8'h00, 8'hFF);
    apply("xload", 1'bx, 1'b1, 2'b01, 8'h77, 8'hFF);

    // Mid-count reset, first edge after release counts normally.
    apply("ld_5", 1'b1, 1'b0, 2'b01, 8'h05, 8'h00);
    apply("up_from5", 1'b0, 1'b1, 2'b01, 8'h00, 8'h00);
    do_reset("midcount");
    apply("post_rst", 1'b0, 1'b1, 2'b01, 8'h00, 8'h00);
    check("post_rst_direct", {28'd0, qa}, 32'h1);

    // Reset while a wrap pulse is high.
    apply("ld_f", 1'b1, 1'b0, 2'b00, 8'hFF, 8'h00);
    apply("wrap_hi", 1'b0, 1'b1, 2'b01, 8'h00, 8'h00);
    do_reset("midpulse");

    // 8-bit: down from 0 wraps to FF, then toggle upper nibble.
    apply("w8_ld0", 1'b1, 1'b0, 2'b00, 8'h00, 8'h00);
    apply("w8_down", 1'b0, 1'b1, 2'b10, 8'h00, 8'h00);
    check("w8_down_direct_q", {24'd0, qc}, 32'hFF);
    check("w8_down_direct_wrap", {31'd0, wc}, 32'h1);
    apply("w8_tog", 1'b0, 1'b1, 2'b11, 8'h00, 8'hF0);
    check("w8_tog_direct", {24'd0, qc}, 32'h0F);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic       r_ld;
      logic       r_en;
      logic [1:0] r_md;
      logic [7:0] r_d;
      logic [7:0] r_t;
      if (k == 200) do_reset("rand_rst");
      r_ld = ($urandom_range(0, 7) == 0);
      r_en = ($urandom_range(0, 3) != 0);
      r_md = 2'($urandom_range(0, 3));
      r_d  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r_d = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00;
      r_t  = 8'($urandom);
      apply("rand", r_ld, r_en, r_md, r_d, r_t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/toggle_counter_param.md
TOGGLE_COUNTER_PARAM -- requirements
Module: toggle_counter_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: operation enable for mode actions.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 hold, 01 count up, 10 count down, 11 masked toggle.
REQ-008 The block SHALL have port t_mask, input, WIDTH bits: per-bit toggle enables, used in mode 11.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-010 The block SHALL have port d, input, WIDTH bits: parallel load data.
REQ-011 The block SHALL have port q, output, WIDTH bits: registered state.
REQ-012 The block SHALL have port q_inverse, output, WIDTH bits: registered bitwise complement of q.
REQ-013 The block SHALL have port tc, output, 1 bit: terminal-count indicator, combinational.
REQ-014 The block SHALL have port wrap, output, 1 bit: registered one-cycle wrap pulse.

Function
REQ-015 Per rising clk edge, priority SHALL be: load, then en with mode, else hold.
REQ-016 load=1 SHALL set q<=d regardless of en and mode, and wrap<=0.
REQ-017 load=0, en=0 SHALL hold q; wrap<=0.
REQ-018 Mode 00 with en=1 SHALL hold q; wrap<=0.
REQ-019 Mode 01 with en=1 SHALL set q<=q+1 modulo 2^WIDTH.
REQ-020 Mode 10 with en=1 SHALL set q<=q-1 modulo 2^WIDTH.
REQ-021 Mode 11 with en=1 SHALL set q<=q XOR t_mask: bitwise T flip-flop behaviour, each bit toggling where its mask bit is 1.
REQ-022 With SATURATE=0, in mode 01 at q=all-ones, q SHALL become 0 and wrap SHALL be 1 for the following cycle.
REQ-023 With SATURATE=0, in mode 10 at q=0, q SHALL become all-ones and wrap SHALL be 1 for the following cycle.
REQ-024 With SATURATE=1, q SHALL hold at all-ones in mode 01 and at 0 in mode 10, and wrap SHALL stay 0.
REQ-025 Mode 11 SHALL never assert wrap; t_mask=0 SHALL hold q.
REQ-026 wrap SHALL be 0 in every cycle not following a wrap event.
REQ-027 tc SHALL be 1 exactly when (mode=01 and q=all-ones) or (mode=10 and q=0), independent of en and load; otherwise 0.
REQ-028 q_inverse SHALL equal ~q at all times, including during and after reset; no independent state is allowed.
REQ-029 Latency from load, en, mode, or t_mask to q SHALL be one clock edge.
REQ-030 X or Z on mode or load with en=1 SHALL hold q, with no X propagation into state.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force q=0, q_inverse=all-ones, and wrap=0.
REQ-032 While rst_n=0, clk edges SHALL have no effect.
REQ-033 The first rising clk edge after rst_n deasserts SHALL act normally.
REQ-034 Reset asserted mid-count or mid-pulse SHALL clear wrap within the same cycle.

Verification (WIDTH=4 unless noted)
REQ-035 Reset, then mode=11, en=1, t_mask=4'b0001 for 4 edges -> q sequence 1,0,1,0; q_inverse sequence E,F,E,F; wrap=0 throughout.
REQ-036 SATURATE=0: load d=4'hE, then mode=01, en=1 for 3 edges -> q sequence F,0,1; tc=1 while q=F; wrap=1 only in the cycle with q=0.
REQ-037 SATURATE=1: load d=4'h1, then mode=10, en=1 for 3 edges -> q sequence 0,0,0; tc=1 while q=0; wrap never asserted.
REQ-038 load=1 with d=4'h9, en=1, mode=01 on the same edge -> q=9, not A; then en=0 for 2 edges -> q stays 9.
REQ-039 Counting up from 4'h5, drive rst_n low between clock edges -> q=0, q_inverse=F immediately; the first edge after release with mode=01 -> q=1.
REQ-040 WIDTH=8, SATURATE=0: load 8'h00, then mode=10, en=1 for 1 edge -> q=8'hFF and wrap=1 next cycle; then mode=11, t_mask=8'hF0 -> q=8'h0F.
